// File: rtl/seq_divider_pkg.sv
// Shared types and defaults for the sequential divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/seq_divider_step.sv
// One restoring shift-subtract step: shift {rem, quo} left, trial-subtract divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    // rem < divisor on entry, so WIDTH+1 bits hold both the shifted value and the sign
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        trial  = rem_sh - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_sh[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, with divide-by-zero flag.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic             load_phase;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dvs_r),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    // LOAD spans two cycles: the first primes the working registers, the second
    // decides between ITER and the divide-by-zero shortcut.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            load_phase  <= 1'b0;
            cnt         <= '0;
            dvd_r       <= '0;
            dvs_r       <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            busy        <= 1'b0;
            ready       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        load_phase <= 1'b0;
                        dvd_r      <= dividend;
                        dvs_r      <= divisor;
                        busy       <= 1'b1;
                        ready      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!load_phase) begin
                        load_phase <= 1'b1;
                        rem_r      <= '0;
                        quo_r      <= dvd_r;
                    end else if (dvs_r == '0) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        ready       <= 1'b1;
                        quotient    <= '1;
                        remainder   <= dvd_r;
                        div_by_zero <= 1'b1;
                    end else begin
                        state <= ITER;
                        cnt   <= '0;
                    end
                end
                ITER: begin
                    rem_r <= rem_nx;
                    quo_r <= quo_nx;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        ready       <= 1'b1;
                        quotient    <= quo_nx;
                        remainder   <= rem_nx;
                        div_by_zero <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH = 32).
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int total = 0;
    int passed = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .ready       (ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Pulse start for one edge, then count edges until ready (bounded).
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic busy_acc, output logic rdy_acc);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        busy_acc = busy;
        rdy_acc  = ready;
        lat = 0;
        while (!ready && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #12;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (ready !== 1'b0) $display("FAIL reset_ready got %b want 0", ready); else passed++;
        total++; if (quotient !== 32'd0) $display("FAIL reset_quot got %h want 0", quotient); else passed++;
        total++; if (remainder !== 32'd0) $display("FAIL reset_rem got %h want 0", remainder); else passed++;
        total++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got %b want 0", div_by_zero); else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat; logic b, r;
        run_div(32'd100, 32'd7, lat, b, r);
        total++; if (b !== 1'b1) $display("FAIL basic_busy got %b want 1", b); else passed++;
        total++; if (lat != 34) $display("FAIL basic_latency got %0d want 34", lat); else passed++;
        total++; if (quotient !== 32'd14) $display("FAIL basic_quot got %0d want 14", quotient); else passed++;
        total++; if (remainder !== 32'd2) $display("FAIL basic_rem got %0d want 2", remainder); else passed++;
        total++; if (div_by_zero !== 1'b0) $display("FAIL basic_dbz got %b want 0", div_by_zero); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL basic_busy_done got %b want 0", busy); else passed++;
    endtask

    task automatic test_div_by_zero();
        int lat; logic b, r;
        run_div(32'h1234, 32'd0, lat, b, r);
        total++; if (lat != 2) $display("FAIL dbz_latency got %0d want 2", lat); else passed++;
        total++; if (quotient !== 32'hFFFF_FFFF) $display("FAIL dbz_quot got %h want ffffffff", quotient); else passed++;
        total++; if (remainder !== 32'h1234) $display("FAIL dbz_rem got %h want 1234", remainder); else passed++;
        total++; if (div_by_zero !== 1'b1) $display("FAIL dbz_flag got %b want 1", div_by_zero); else passed++;
        dividend = 32'd77;
        divisor  = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        total++; if (ready !== 1'b1) $display("FAIL dbz_hold_ready got %b want 1", ready); else passed++;
        total++; if (remainder !== 32'h1234) $display("FAIL dbz_hold_rem got %h want 1234", remainder); else passed++;
    endtask

    task automatic test_extremes();
        int lat; logic b, r;
        run_div(32'hFFFF_FFFF, 32'd1, lat, b, r);
        total++; if (quotient !== 32'hFFFF_FFFF) $display("FAIL max_quot got %h want ffffffff", quotient); else passed++;
        total++; if (remainder !== 32'd0) $display("FAIL max_rem got %h want 0", remainder); else passed++;
        total++; if (div_by_zero !== 1'b0) $display("FAIL max_dbz got %b want 0", div_by_zero); else passed++;
        run_div(32'd5, 32'd9, lat, b, r);
        total++; if (quotient !== 32'd0) $display("FAIL small_quot got %0d want 0", quotient); else passed++;
        total++; if (remainder !== 32'd5) $display("FAIL small_rem got %0d want 5", remainder); else passed++;
    endtask

    task automatic test_start_while_busy();
        int lat;
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd10;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (!ready && lat < 100) begin
            if (lat == 9) begin
                @(negedge clk);
                dividend = 32'd7;
                divisor  = 32'd7;
                start    = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        total++; if (lat != 34) $display("FAIL busy_latency got %0d want 34", lat); else passed++;
        total++; if (quotient !== 32'd100) $display("FAIL busy_quot got %0d want 100", quotient); else passed++;
        total++; if (remainder !== 32'd0) $display("FAIL busy_rem got %0d want 0", remainder); else passed++;
    endtask

    task automatic test_reset_mid();
        int lat; logic b, r;
        @(negedge clk);
        dividend = 32'd50;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passed++;
        total++; if (ready !== 1'b0) $display("FAIL midrst_ready got %b want 0", ready); else passed++;
        total++; if (quotient !== 32'd0) $display("FAIL midrst_quot got %h want 0", quotient); else passed++;
        total++; if (remainder !== 32'd0) $display("FAIL midrst_rem got %h want 0", remainder); else passed++;
        @(negedge clk);
        reset = 1'b0;
        run_div(32'd50, 32'd3, lat, b, r);
        total++; if (lat != 34) $display("FAIL midrst_latency got %0d want 34", lat); else passed++;
        total++; if (quotient !== 32'd16) $display("FAIL midrst_quot2 got %0d want 16", quotient); else passed++;
        total++; if (remainder !== 32'd2) $display("FAIL midrst_rem2 got %0d want 2", remainder); else passed++;
    endtask

    task automatic test_back_to_back();
        int lat; logic b, r;
        total++; if (ready !== 1'b1) $display("FAIL b2b_pre_ready got %b want 1", ready); else passed++;
        run_div(32'd81, 32'd9, lat, b, r);
        total++; if (r !== 1'b0) $display("FAIL b2b_ready_drop got %b want 0", r); else passed++;
        total++; if (b !== 1'b1) $display("FAIL b2b_busy got %b want 1", b); else passed++;
        total++; if (lat != 34) $display("FAIL b2b_latency got %0d want 34", lat); else passed++;
        total++; if (quotient !== 32'd9) $display("FAIL b2b_quot got %0d want 9", quotient); else passed++;
        total++; if (remainder !== 32'd0) $display("FAIL b2b_rem got %0d want 0", remainder); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_by_zero();
        test_extremes();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
